// File: rtl/grahzm_core_if.sv
// grahzm_core_if: program fetch plus valid/ready input and output ports of grahzm_core.
interface grahzm_core_if #(parameter int WIDTH = 8, parameter int PC_WIDTH = 8);
   logic [PC_WIDTH-1:0] prog_addr;
   logic [7:0] prog_data;
   logic [WIDTH-1:0] in_data;
   logic in_valid;
   logic in_ready;
   logic [WIDTH-1:0] out_data;
   logic out_valid;
   logic out_ready;
   logic stall;
   modport master (output prog_addr, in_ready, out_data, out_valid, stall,
                   input prog_data, in_data, in_valid, out_ready);
   modport slave (input prog_addr, in_ready, out_data, out_valid, stall,
                  output prog_data, in_data, in_valid, out_ready);
endinterface

// File: rtl/grahzm_core.sv
// grahzm_core: single-issue register CPU with six registers, word RAM and handshaked I/O ports.
module grahzm_core #(
   parameter int WIDTH = 8,
   parameter int RAM_DEPTH = 256,
   parameter int PC_WIDTH = 8
) (
   input logic clk,
   input logic rst,
   grahzm_core_if.master bus
);
   localparam int AW = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] r_q [6];
   logic [WIDTH-1:0] r_d [6];
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic out_valid_q, out_valid_d;
   logic [WIDTH-1:0] ram [RAM_DEPTH];
   logic [1:0] cls;
   logic [2:0] src, dst, op;
   logic is_copy, need_in, need_out, blocked, go, ram_we, zero, neg, base, taken;
   logic [WIDTH-1:0] src_val, alu;
   logic [AW-1:0] ram_addr;
   assign cls = bus.prog_data[7:6];
   assign src = bus.prog_data[5:3];
   assign dst = bus.prog_data[2:0];
   assign op = bus.prog_data[2:0];
   assign ram_addr = r_q[4][AW-1:0];
   always_comb begin
      is_copy = cls == 2'b10;
      need_in = is_copy && src == 3'd7;
      need_out = is_copy && dst == 3'd7;
      blocked = (need_in && !bus.in_valid) || (need_out && out_valid_q && !bus.out_ready);
      go = !rst && !blocked;
      ram_we = go && is_copy && dst == 3'd6;
      src_val = src == 3'd7 ? bus.in_data : src == 3'd6 ? ram[ram_addr] : r_q[src];
   end
   always_comb begin
      alu = '0;
      case (op)
         3'd0: alu = r_q[1] | r_q[2];
         3'd1: alu = ~(r_q[1] & r_q[2]);
         3'd2: alu = ~(r_q[1] | r_q[2]);
         3'd3: alu = r_q[1] & r_q[2];
         3'd4: alu = r_q[1] + r_q[2];
         3'd5: alu = r_q[1] - r_q[2];
         3'd6: alu = r_q[1] ^ r_q[2];
         default: alu = r_q[1] << 1;
      endcase
   end
   // codes 4..7 are the complements of codes 0..3
   always_comb begin
      zero = r_q[3] == '0;
      neg = r_q[3][WIDTH-1];
      base = op[1:0] == 2'd0 ? 1'b0 : op[1:0] == 2'd1 ? zero : op[1:0] == 2'd2 ? neg : zero | neg;
      taken = base ^ op[2];
   end
   always_comb begin
      pc_d = pc_q;
      r_d = r_q;
      out_data_d = out_data_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      if (go) begin
         pc_d = (cls == 2'b11 && taken) ? PC_WIDTH'(r_q[0]) : pc_q + 1'b1;
         if (cls == 2'b00) r_d[0] = WIDTH'(bus.prog_data[5:0]);
         if (cls == 2'b01) r_d[3] = alu;
         if (is_copy && dst < 3'd6) r_d[dst] = src_val;
         if (need_out) begin
            out_data_d = src_val;
            out_valid_d = 1'b1;
         end
      end
   end
   assign bus.prog_addr = rst ? '0 : pc_q;
   assign bus.stall = !rst && blocked;
   assign bus.in_ready = !rst && need_in && !blocked;
   assign bus.out_data = out_data_q;
   assign bus.out_valid = out_valid_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
         r_q <= '{default: '0};
         out_data_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         r_q <= r_d;
         out_data_q <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end
   // RAM is deliberately outside reset so its contents survive rst
   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= src_val;
   end
endmodule

// File: tb/tb_grahzm_core.sv
// tb_grahzm_core: directed and random checks of grahzm_core against an instruction-level model.
module tb_grahzm_core;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   grahzm_core_if #(.WIDTH(8), .PC_WIDTH(8)) ifc ();
   grahzm_core_if #(.WIDTH(16), .PC_WIDTH(8)) ifc16 ();
   grahzm_core #(.WIDTH(8), .RAM_DEPTH(256), .PC_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(ifc));
   grahzm_core #(.WIDTH(16), .RAM_DEPTH(256), .PC_WIDTH(8)) dut16 (.clk(clk), .rst(rst), .bus(ifc16));
   logic [7:0] rom [256];
   logic [7:0] rom16 [256];
   assign ifc.prog_data = rom[ifc.prog_addr];
   assign ifc16.prog_data = rom16[ifc16.prog_addr];
   assign ifc16.in_data = '0;
   assign ifc16.in_valid = 1'b0;
   assign ifc16.out_ready = 1'b0;
   int vecs = 0, errs = 0;
   int m_pc, m_od;
   int m_r [6];
   int m_ram [256];
   bit m_ov;
   bit e_stall, e_ir;
   int e_pa;
   function automatic int alu(input int op, input int a, input int b);
      int r;
      case (op)
         0: r = a | b;
         1: r = ~(a & b);
         2: r = ~(a | b);
         3: r = a & b;
         4: r = a + b;
         5: r = a - b;
         6: r = a ^ b;
         default: r = a * 2;
      endcase
      return r & 255;
   endfunction
   function automatic bit cond(input int c, input int r3);
      int v = r3 > 127 ? r3 - 256 : r3;
      case (c)
         0: return 0;
         1: return v == 0;
         2: return v < 0;
         3: return v <= 0;
         4: return 1;
         5: return v != 0;
         6: return v >= 0;
         default: return v > 0;
      endcase
   endfunction
   task automatic apply(input bit r, input bit iv, input int id, input bit ordy);
      int ins, s, d;
      bit cp;
      rst = r;
      ifc.in_valid = iv;
      ifc.in_data = 8'(id);
      ifc.out_ready = ordy;
      ins = int'(rom[m_pc]);
      s = (ins >> 3) & 7;
      d = ins & 7;
      cp = (ins >> 6) == 2;
      e_stall = !r && cp && ((s == 7 && !iv) || (d == 7 && m_ov && !ordy));
      e_ir = !r && cp && s == 7 && !e_stall;
      e_pa = r ? 0 : m_pc;
      #1;
   endtask
   task automatic tick();
      int ins, s, d, v;
      @(posedge clk);
      ins = int'(rom[m_pc]);
      s = (ins >> 3) & 7;
      d = ins & 7;
      if (rst) begin
         m_pc = 0;
         m_r = '{default: 0};
         m_od = 0;
         m_ov = 0;
      end else begin
         if (m_ov && ifc.out_ready) m_ov = 0;
         if (!e_stall) begin
            case (ins >> 6)
               0: m_r[0] = ins & 63;
               1: m_r[3] = alu(ins & 7, m_r[1], m_r[2]);
               2: begin
                  v = s < 6 ? m_r[s] : s == 6 ? m_ram[m_r[4] % 256] : int'(ifc.in_data);
                  if (d < 6) m_r[d] = v;
                  else if (d == 6) m_ram[m_r[4] % 256] = v;
                  else begin
                     m_od = v;
                     m_ov = 1;
                  end
               end
               default: ;
            endcase
            m_pc = ((ins >> 6) == 3 && cond(d, m_r[3])) ? m_r[0] : (m_pc + 1) % 256;
         end
      end
      @(negedge clk);
   endtask
   task automatic reset_dut();
      apply(1, 0, 0, 0);
      tick();
   endtask
   task automatic test_reset();
      rom = '{default: 8'h00};
      for (int i = 0; i < 2; i++) begin
         apply(1, 1'($urandom), $urandom, 1'($urandom));
         vecs++;
         if ({ifc.prog_addr, ifc.stall, ifc.in_ready} !== 10'b0) begin
            $display("FAIL reset_comb: got addr=%h stall=%b in_ready=%b, want 0 0 0", ifc.prog_addr, ifc.stall, ifc.in_ready);
            errs++;
         end
         tick();
      end
      apply(0, 0, 0, 0);
      vecs++;
      if ({ifc.prog_addr, ifc.out_valid, ifc.out_data} !== 17'b0) begin
         $display("FAIL reset_state: got addr=%h out_valid=%b out_data=%h, want 0 0 0", ifc.prog_addr, ifc.out_valid, ifc.out_data);
         errs++;
      end
   endtask
   task automatic test_alu();
      rom = '{default: 8'h00};
      rom[0:11] = '{8'h05, 8'h81, 8'h03, 8'h82, 8'h44, 8'h9F, 8'h00, 8'h81, 8'h01, 8'h82, 8'h45, 8'h9F};
      reset_dut();
      for (int k = 1; k <= 12; k++) begin
         apply(0, 0, 0, 1);
         tick();
         if (k == 6 || k == 12) begin
            vecs++;
            if ({ifc.out_valid, ifc.out_data} !== {1'b1, (k == 6 ? 8'h08 : 8'hFF)}) begin
               $display("FAIL alu_%0d: got valid=%b data=%h, want 1 %h", k, ifc.out_valid, ifc.out_data, k == 6 ? 8'h08 : 8'hFF);
               errs++;
            end
         end
      end
   endtask
   task automatic test_jump();
      rom = '{default: 8'h00};
      rom[0:5] = '{8'h01, 8'h82, 8'h45, 8'h10, 8'hC7, 8'hC2};
      rom[16:26] = '{8'h3F, 8'h81, 8'h47, 8'h99, 8'h47, 8'h99, 8'h03, 8'h82, 8'h40, 8'h98, 8'hC4};
      reset_dut();
      for (int k = 1; k <= 18; k++) begin
         apply(0, 0, 0, 1);
         tick();
         if (k == 5 || k == 6 || k == 17 || k == 18) begin
            vecs++;
            if (ifc.prog_addr !== (k == 5 ? 8'h05 : k == 6 ? 8'h10 : k == 17 ? 8'hFF : 8'h00)) begin
               $display("FAIL jump_%0d: got addr=%h", k, ifc.prog_addr);
               errs++;
            end
         end
      end
   endtask
   task automatic test_backpressure();
      rom = '{default: 8'h00};
      rom[0:2] = '{8'h09, 8'h87, 8'h87};
      reset_dut();
      apply(0, 0, 0, 0);
      tick();
      apply(0, 0, 0, 0);
      vecs++;
      if (ifc.stall !== 1'b0) begin
         $display("FAIL bp_first: got stall=%b want 0", ifc.stall);
         errs++;
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         apply(0, 0, 0, 0);
         vecs++;
         if ({ifc.stall, ifc.prog_addr, ifc.out_valid, ifc.out_data} !== {1'b1, 8'h02, 1'b1, 8'h09}) begin
            $display("FAIL bp_hold: got stall=%b addr=%h valid=%b data=%h, want 1 02 1 09", ifc.stall, ifc.prog_addr, ifc.out_valid, ifc.out_data);
            errs++;
         end
         tick();
      end
      apply(0, 0, 0, 1);
      vecs++;
      if (ifc.stall !== 1'b0) begin
         $display("FAIL bp_release: got stall=%b want 0", ifc.stall);
         errs++;
      end
      tick();
      vecs++;
      if ({ifc.out_valid, ifc.prog_addr} !== {1'b1, 8'h03}) begin
         $display("FAIL bp_refill: got valid=%b addr=%h, want 1 03", ifc.out_valid, ifc.prog_addr);
         errs++;
      end
      apply(0, 0, 0, 1);
      tick();
      vecs++;
      if (ifc.out_valid !== 1'b0) begin
         $display("FAIL bp_drain: got valid=%b want 0", ifc.out_valid);
         errs++;
      end
   endtask
   task automatic test_input_stall();
      rom = '{default: 8'h00};
      rom[0:1] = '{8'hBA, 8'h97};
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, $urandom, 1);
         vecs++;
         if ({ifc.stall, ifc.in_ready, ifc.prog_addr} !== {1'b1, 1'b0, 8'h00}) begin
            $display("FAIL in_wait: got stall=%b in_ready=%b addr=%h, want 1 0 00", ifc.stall, ifc.in_ready, ifc.prog_addr);
            errs++;
         end
         tick();
      end
      apply(0, 1, 8'h2A, 1);
      vecs++;
      if ({ifc.stall, ifc.in_ready} !== 2'b01) begin
         $display("FAIL in_take: got stall=%b in_ready=%b, want 0 1", ifc.stall, ifc.in_ready);
         errs++;
      end
      tick();
      apply(0, 0, 0, 1);
      vecs++;
      if ({ifc.in_ready, ifc.prog_addr} !== {1'b0, 8'h01}) begin
         $display("FAIL in_adv: got in_ready=%b addr=%h, want 0 01", ifc.in_ready, ifc.prog_addr);
         errs++;
      end
      tick();
      vecs++;
      if ({ifc.out_valid, ifc.out_data} !== {1'b1, 8'h2A}) begin
         $display("FAIL in_data: got valid=%b data=%h, want 1 2a", ifc.out_valid, ifc.out_data);
         errs++;
      end
   endtask
   task automatic test_ram();
      bit done = 0;
      rom = '{default: 8'h00};
      rom[0:21] = '{8'hAE, 8'hA1, 8'h01, 8'h82, 8'h44, 8'h9C, 8'h00, 8'hC5,
                    8'h07, 8'h84, 8'h33, 8'h86, 8'h08, 8'h84, 8'h11, 8'h86,
                    8'h07, 8'h84, 8'hB1, 8'h8F, 8'h14, 8'hC4};
      reset_dut();
      for (int i = 0; i < 3000 && !done; i++) begin
         apply(0, 0, 0, 1);
         vecs++;
         if ({ifc.prog_addr, ifc.stall, ifc.in_ready, ifc.out_valid, ifc.out_data} !== {8'(e_pa), e_stall, e_ir, m_ov, 8'(m_od)}) begin
            $display("FAIL ram_cycle: got addr=%h stall=%b ir=%b ov=%b od=%h, want %h %b %b %b %h", ifc.prog_addr, ifc.stall, ifc.in_ready, ifc.out_valid, ifc.out_data, 8'(e_pa), e_stall, e_ir, m_ov, 8'(m_od));
            errs++;
         end
         tick();
         done = ifc.out_valid;
      end
      vecs++;
      if ({done, ifc.out_data} !== {1'b1, 8'h33}) begin
         $display("FAIL ram_read: got done=%b data=%h, want 1 33", done, ifc.out_data);
         errs++;
      end
   endtask
   task automatic test_random();
      for (int seg = 0; seg < 4; seg++) begin
         foreach (rom[i]) rom[i] = 8'($urandom);
         reset_dut();
         for (int i = 0; i < 500; i++) begin
            apply($urandom_range(0, 96) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
            vecs++;
            if ({ifc.prog_addr, ifc.stall, ifc.in_ready, ifc.out_valid, ifc.out_data} !== {8'(e_pa), e_stall, e_ir, m_ov, 8'(m_od)}) begin
               $display("FAIL rand_cycle: got addr=%h stall=%b ir=%b ov=%b od=%h, want %h %b %b %b %h", ifc.prog_addr, ifc.stall, ifc.in_ready, ifc.out_valid, ifc.out_data, 8'(e_pa), e_stall, e_ir, m_ov, 8'(m_od));
               errs++;
            end
            tick();
         end
      end
   endtask
   task automatic test_alias();
      reset_dut();
      for (int i = 0; i < 40; i++) begin
         apply(0, 0, 0, 0);
         tick();
      end
      vecs++;
      if ({ifc16.out_valid, ifc16.out_data} !== {1'b1, 16'h0033}) begin
         $display("FAIL alias16: got valid=%b data=%h, want 1 0033", ifc16.out_valid, ifc16.out_data);
         errs++;
      end
   endtask
   initial begin
      rst = 1'b1;
      ifc.in_valid = 1'b0;
      ifc.in_data = '0;
      ifc.out_ready = 1'b0;
      m_pc = 0;
      m_od = 0;
      m_ov = 0;
      m_r = '{default: 0};
      m_ram = '{default: 0};
      rom16 = '{default: 8'h00};
      rom16[0:1] = '{8'h01, 8'h81};
      for (int i = 0; i < 8; i++) begin
         rom16[2 + 2 * i] = 8'h47;
         rom16[3 + 2 * i] = 8'h99;
      end
      rom16[18:28] = '{8'h07, 8'h82, 8'h40, 8'h9C, 8'h33, 8'h86, 8'h07, 8'h84, 8'hB7, 8'h1B, 8'hC4};
      test_reset();
      test_alu();
      test_jump();
      test_backpressure();
      test_input_stall();
      test_ram();
      test_random();
      test_alias();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
